// File: rtl/mul_pipe_if.sv
// mul_pipe_if: operand/result bundle for the mul_pipe multiplier.
// The master side drives CE, IN_VALID and the operands; the slave side
// (the multiplier) returns OUT_VALID, the product slice P and OVF.
interface mul_pipe_if #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int P_WIDTH = 8
);
  logic               CE;
  logic               IN_VALID;
  logic [A_WIDTH-1:0] A;
  logic [B_WIDTH-1:0] B;
  logic               OUT_VALID;
  logic [P_WIDTH-1:0] P;
  logic               OVF;

  modport master (
    output CE, IN_VALID, A, B,
    input  OUT_VALID, P, OVF
  );

  modport slave (
    input  CE, IN_VALID, A, B,
    output OUT_VALID, P, OVF
  );
endinterface

// File: rtl/mul_pipe.sv
// mul_pipe: parametrised pipelined integer multiplier.
// Operands are extended per their signedness, multiplied exactly in stage 0,
// then a P_WIDTH slice starting at bit P_SHIFT (floor shift) is delayed
// through LATENCY-1 further stages together with a valid bit.
// Optional build macro MUL_SAT_EN: saturate the slice on overflow and
// report OVF; without it the slice wraps and OVF is constant 0.
//
// Handshake: valid-only, no backpressure. An operation is accepted on a
// rising CLK edge where CE=1 and IN_VALID=1; OUT_VALID marks P/OVF as a
// result. CE=0 freezes every stage, which is how the pipeline stalls.
module mul_pipe #(
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 8,
  parameter int A_SIGNED = 1,
  parameter int B_SIGNED = 1,
  parameter int P_WIDTH  = 8,
  parameter int P_SHIFT  = 0,
  parameter int LATENCY  = 3
) (
  input logic     CLK,
  input logic     RESET,
  mul_pipe_if.slave bus
);

  // Two guard bits over the exact product width keep the extended
  // operand product free of any wrap, including most-negative x most-negative.
  localparam int FW = A_WIDTH + B_WIDTH + 2;

  // Illegal configurations stop elaboration.
  if (A_WIDTH < 1 || B_WIDTH < 1) begin : g_bad_width
    $error("mul_pipe: operand widths must be >= 1");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("mul_pipe: LATENCY must be >= 1");
  end
  if (P_WIDTH < 1 || P_WIDTH > A_WIDTH + B_WIDTH) begin : g_bad_pwidth
    $error("mul_pipe: P_WIDTH must be within 1..A_WIDTH+B_WIDTH");
  end
  if (P_SHIFT < 0 || P_SHIFT > A_WIDTH + B_WIDTH - P_WIDTH) begin : g_bad_pshift
    $error("mul_pipe: slice lies outside the product");
  end

  logic signed [A_WIDTH:0] a_ext;
  logic signed [B_WIDTH:0] b_ext;
  logic signed [FW-1:0]    a_full;
  logic signed [FW-1:0]    b_full;
  logic signed [FW-1:0]    full;
  logic signed [FW-1:0]    shifted;
  logic [P_WIDTH-1:0]      slice_d;

  // One extra bit per operand makes both operands signed values.
  if (A_SIGNED != 0) begin : g_a_sx
    assign a_ext = {bus.A[A_WIDTH-1], bus.A};
  end else begin : g_a_zx
    assign a_ext = {1'b0, bus.A};
  end

  if (B_SIGNED != 0) begin : g_b_sx
    assign b_ext = {bus.B[B_WIDTH-1], bus.B};
  end else begin : g_b_zx
    assign b_ext = {1'b0, bus.B};
  end

  assign a_full  = FW'(a_ext);
  assign b_full  = FW'(b_ext);
  assign full    = a_full * b_full;
  assign shifted = full >>> P_SHIFT;

  logic [P_WIDTH-1:0] p_q [LATENCY];
  logic [LATENCY-1:0] v_q;

`ifdef MUL_SAT_EN
  localparam bit SLICE_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
  localparam logic signed [FW-1:0] ONE = 1;
  localparam logic signed [FW-1:0] HI  = SLICE_SIGNED ? (ONE <<< (P_WIDTH - 1)) - ONE
                                                      : (ONE <<< P_WIDTH) - ONE;
  localparam logic signed [FW-1:0] LO  = SLICE_SIGNED ? -HI - ONE : '0;

  logic               ovf_d;
  logic [LATENCY-1:0] ovf_q;

  // Clamp the shifted product to the slice type's range and flag the clamp.
  always_comb begin
    ovf_d   = 1'b0;
    slice_d = P_WIDTH'(shifted);
    if (shifted > HI) begin
      ovf_d   = 1'b1;
      slice_d = P_WIDTH'(HI);
    end else if (shifted < LO) begin
      ovf_d   = 1'b1;
      slice_d = P_WIDTH'(LO);
    end
  end

  // OVF travels beside P: same reset, same CE freeze, same delay.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q <= '0;
    end else if (bus.CE) begin
      ovf_q[0] <= ovf_d;
      for (int i = 1; i < LATENCY; i++) begin
        ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

  assign bus.OVF = ovf_q[LATENCY-1];
`else
  // Plain truncation: the slice wraps.
  assign slice_d = P_WIDTH'(shifted);
  assign bus.OVF = 1'b0;
`endif

  // Data and valid pipeline: stage 0 captures the slice, later stages delay.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < LATENCY; i++) begin
        p_q[i] <= '0;
      end
      v_q <= '0;
    end else if (bus.CE) begin
      p_q[0] <= slice_d;
      v_q[0] <= bus.IN_VALID;
      for (int i = 1; i < LATENCY; i++) begin
        p_q[i] <= p_q[i-1];
        v_q[i] <= v_q[i-1];
      end
    end
  end

  assign bus.P         = p_q[LATENCY-1];
  assign bus.OUT_VALID = v_q[LATENCY-1];

endmodule
